// File: rtl/lfsr_gen_if.sv
// Bundles the LFSR generator's control inputs and status/data outputs.
// The master drives mode/din/rand_ready; the slave (lfsr_gen) drives the rest.
interface lfsr_gen_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic [WIDTH-1:0] din;
    logic [1:0]       mode;
    logic             rand_ready;
    logic [WIDTH-1:0] data;
    logic             rand_valid;
    logic             lockup;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] period_len;
    logic             period_pulse;

    modport master (
        output din, mode, rand_ready,
        input  data, rand_valid, lockup, step_cnt, period_len, period_pulse
    );

    modport slave (
        input  din, mode, rand_ready,
        output data, rand_valid, lockup, step_cnt, period_len, period_pulse
    );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci-style right-shifting LFSR with load/reseed, backpressure,
// all-zero lockup recovery and cycle-length measurement.
module lfsr_gen #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
    parameter logic [WIDTH-1:0] SEED  = 8'h01,
    parameter int unsigned      CNT_W = 16
) (
    input logic       clk,
    input logic       rst_n,
    lfsr_gen_if.slave bus
);
    localparam logic [1:0] ModeReseed = 2'b00;
    localparam logic [1:0] ModeLoad   = 2'b01;
    localparam logic [1:0] ModeRun    = 2'b10;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic             lockup_q, lockup_d;
    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic [CNT_W-1:0] period_len_q, period_len_d;
    logic             period_pulse_q;
    logic             hit;
    logic             fb;
    logic [WIDTH-1:0] step_data;

    assign fb        = ^(data_q & TAPS);
    assign step_data = {fb, data_q[WIDTH-1:1]};

    always_comb begin
        data_d       = data_q;
        start_d      = start_q;
        lockup_d     = lockup_q;
        step_cnt_d   = step_cnt_q;
        period_len_d = period_len_q;
        hit          = 1'b0;
        case (bus.mode)
            ModeReseed: begin
                data_d     = SEED;
                start_d    = SEED;
                step_cnt_d = '0;
                lockup_d   = 1'b0;
            end
            ModeLoad: begin
                data_d     = bus.din;
                start_d    = bus.din;
                step_cnt_d = '0;
                lockup_d   = 1'b0;
            end
            ModeRun: begin
                if (bus.rand_ready) begin
                    if (data_q == '0) begin
                        // All-zero state never advances; restart from the seed instead
                        data_d     = SEED;
                        start_d    = SEED;
                        lockup_d   = 1'b1;
                        step_cnt_d = '0;
                    end else if (step_data == start_q) begin
                        hit          = 1'b1;
                        data_d       = step_data;
                        period_len_d = step_cnt_q + 1'b1;
                        step_cnt_d   = '0;
                    end else begin
                        data_d = step_data;
                        if (step_cnt_q != {CNT_W{1'b1}}) begin
                            step_cnt_d = step_cnt_q + 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q         <= SEED;
            start_q        <= SEED;
            lockup_q       <= 1'b0;
            step_cnt_q     <= '0;
            period_len_q   <= '0;
            period_pulse_q <= 1'b0;
        end else begin
            data_q         <= data_d;
            start_q        <= start_d;
            lockup_q       <= lockup_d;
            step_cnt_q     <= step_cnt_d;
            period_len_q   <= period_len_d;
            // Follows the hit alone so a load/reseed next cycle cannot mask it
            period_pulse_q <= hit;
        end
    end

    assign bus.data         = data_q;
    assign bus.rand_valid   = (bus.mode == ModeRun);
    assign bus.lockup       = lockup_q;
    assign bus.step_cnt     = step_cnt_q;
    assign bus.period_len   = period_len_q;
    assign bus.period_pulse = period_pulse_q;
endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed table, corner sequences and
// randomized traffic against a behavioural model.
module tb_lfsr_gen;
    localparam logic [7:0] TAPS = 8'h1D;
    localparam logic [7:0] SEED = 8'h01;
    localparam logic [1:0] M_RESEED = 2'b00;
    localparam logic [1:0] M_LOAD   = 2'b01;
    localparam logic [1:0] M_RUN    = 2'b10;
    localparam logic [1:0] M_HOLD   = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lfsr_gen_if #(.WIDTH(8), .CNT_W(16)) bus ();

    lfsr_gen #(.WIDTH(8), .TAPS(TAPS), .SEED(SEED), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state; step count kept unbounded and saturated on compare
    logic [7:0]  m_data, m_start;
    logic        m_lock, m_pulse;
    int          m_steps;
    logic [15:0] m_plen;

    typedef struct {
        logic [1:0]  mode;
        logic        ready;
        logic [7:0]  din;
        logic [7:0]  exp_data;
        logic [15:0] exp_cnt;
        logic        exp_lock;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        int ones;
        ones = $countones(s & TAPS);
        return (s >> 1) | ((ones % 2) == 1 ? 8'h80 : 8'h00);
    endfunction

    function automatic int cycle_len(input logic [7:0] s0);
        logic [7:0] s;
        int n;
        s = s0;
        n = 0;
        do begin
            s = lfsr_next(s);
            n++;
        end while (s != s0 && n < 1000);
        return n;
    endfunction

    function automatic logic [15:0] sat_cnt();
        return (m_steps > 65535) ? 16'hFFFF : 16'(m_steps);
    endfunction

    task automatic model_reset();
        m_data  = SEED;
        m_start = SEED;
        m_lock  = 1'b0;
        m_pulse = 1'b0;
        m_steps = 0;
        m_plen  = 16'h0;
    endtask

    task automatic model_step(input logic [1:0] m, input logic r, input logic [7:0] d);
        logic [7:0] nxt;
        m_pulse = 1'b0;
        if (m == M_RESEED || m == M_LOAD) begin
            m_data  = (m == M_RESEED) ? SEED : d;
            m_start = m_data;
            m_steps = 0;
            m_lock  = 1'b0;
        end else if (m == M_RUN && r) begin
            if (m_data == 8'h00) begin
                m_data  = SEED;
                m_start = SEED;
                m_lock  = 1'b1;
                m_steps = 0;
            end else begin
                nxt = lfsr_next(m_data);
                if (nxt == m_start) begin
                    m_plen  = 16'(sat_cnt() + 16'd1);
                    m_steps = 0;
                    m_pulse = 1'b1;
                end else begin
                    m_steps++;
                end
                m_data = nxt;
            end
        end
    endtask

    // Called at a falling edge; returns at the next falling edge
    task automatic apply(input logic [1:0] m, input logic r, input logic [7:0] d);
        bus.mode       = m;
        bus.rand_ready = r;
        bus.din        = d;
        #1;
        check("rand_valid", bus.rand_valid, m == M_RUN);
        @(posedge clk);
        model_step(m, r, d);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data"}, bus.data, m_data);
        check({tag, ".step_cnt"}, bus.step_cnt, sat_cnt());
        check({tag, ".lockup"}, bus.lockup, m_lock);
        check({tag, ".period_len"}, bus.period_len, m_plen);
        check({tag, ".period_pulse"}, bus.period_pulse, m_pulse);
    endtask

    vec_t vecs[12];

    initial begin
        int exp_len;
        int steps;
        bit got;
        int unsigned r;
        logic [1:0] m;
        logic rdy;
        logic [7:0] d;

        vecs[0]  = '{M_RUN,    1'b1, 8'h00, 8'h80, 16'd1, 1'b0};
        vecs[1]  = '{M_RUN,    1'b1, 8'h00, 8'h40, 16'd2, 1'b0};
        vecs[2]  = '{M_RESEED, 1'b0, 8'h00, 8'h01, 16'd0, 1'b0};
        vecs[3]  = '{M_RUN,    1'b1, 8'h00, 8'h80, 16'd1, 1'b0};
        vecs[4]  = '{M_RUN,    1'b0, 8'h00, 8'h80, 16'd1, 1'b0};
        vecs[5]  = '{M_RUN,    1'b1, 8'h00, 8'h40, 16'd2, 1'b0};
        vecs[6]  = '{M_LOAD,   1'b0, 8'h00, 8'h00, 16'd0, 1'b0};
        vecs[7]  = '{M_RUN,    1'b1, 8'h00, 8'h01, 16'd0, 1'b1};
        vecs[8]  = '{M_HOLD,   1'b1, 8'h00, 8'h01, 16'd0, 1'b1};
        vecs[9]  = '{M_RUN,    1'b1, 8'h00, 8'h80, 16'd1, 1'b1};
        vecs[10] = '{M_RESEED, 1'b1, 8'h00, 8'h01, 16'd0, 1'b0};
        vecs[11] = '{M_LOAD,   1'b1, 8'hA5, 8'hA5, 16'd0, 1'b0};

        bus.mode       = M_HOLD;
        bus.rand_ready = 1'b0;
        bus.din        = 8'h00;
        rst_n          = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset.data", bus.data, 8'h01);
        check("reset.step_cnt", bus.step_cnt, 16'h0);
        check("reset.lockup", bus.lockup, 1'b0);
        check("reset.period_len", bus.period_len, 16'h0);
        check("reset.period_pulse", bus.period_pulse, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].mode, vecs[i].ready, vecs[i].din);
            check($sformatf("vec%0d.data", i), bus.data, vecs[i].exp_data);
            check($sformatf("vec%0d.step_cnt", i), bus.step_cnt, vecs[i].exp_cnt);
            check($sformatf("vec%0d.lockup", i), bus.lockup, vecs[i].exp_lock);
            check($sformatf("vec%0d.period_len", i), bus.period_len, 16'h0);
            check($sformatf("vec%0d.period_pulse", i), bus.period_pulse, 1'b0);
        end

        // Full cycle from 0x01 until the period pulse
        exp_len = cycle_len(8'h01);
        apply(M_LOAD, 1'b0, 8'h01);
        steps = 0;
        got   = 1'b0;
        while (!got && steps < 600) begin
            apply(M_RUN, 1'b1, 8'h00);
            steps++;
            if (bus.period_pulse === 1'b1) got = 1'b1;
        end
        check("period.seen", got, 1'b1);
        check("period.steps", steps, exp_len);
        check("period.len", bus.period_len, exp_len);
        check("period.data", bus.data, 8'h01);
        check("period.step_cnt", bus.step_cnt, 16'h0);
        check_model("period");
        apply(M_HOLD, 1'b1, 8'h00);
        check("period.pulse_clear", bus.period_pulse, 1'b0);
        check("period.len_kept", bus.period_len, exp_len);

        // Hold must freeze everything, ready or not
        apply(M_RUN, 1'b1, 8'h00);
        apply(M_RUN, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) begin
            apply(M_HOLD, 1'b1, 8'h00);
            check("hold.data", bus.data, 8'h40);
            check("hold.step_cnt", bus.step_cnt, 16'd2);
            check("hold.period_len", bus.period_len, exp_len);
            check("hold.period_pulse", bus.period_pulse, 1'b0);
        end

        // Lockup recovery, then async reset mid-run
        apply(M_LOAD, 1'b0, 8'h00);
        apply(M_RUN, 1'b1, 8'h00);
        check("lock.data", bus.data, 8'h01);
        check("lock.flag", bus.lockup, 1'b1);
        check("lock.step_cnt", bus.step_cnt, 16'h0);
        apply(M_RUN, 1'b1, 8'h00);
        apply(M_RUN, 1'b1, 8'h00);
        check("prerst.data", bus.data, 8'h40);
        bus.mode       = M_RUN;
        bus.rand_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.data", bus.data, 8'h01);
        check("async_rst.step_cnt", bus.step_cnt, 16'h0);
        check("async_rst.lockup", bus.lockup, 1'b0);
        check("async_rst.period_len", bus.period_len, 16'h0);
        check("async_rst.period_pulse", bus.period_pulse, 1'b0);
        @(posedge clk);
        #1;
        check("rst_hold.data", bus.data, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        apply(M_RUN, 1'b1, 8'h00);
        check("first_step.data", bus.data, 8'h80);
        check("first_step.step_cnt", bus.step_cnt, 16'd1);
        apply(M_RESEED, 1'b0, 8'h00);
        check_model("reseed");

        // Random traffic: a busy phase, then a sparse one that lets periods complete
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < (ph == 0 ? 1500 : 3000); i++) begin
                r = $urandom_range(0, 999);
                if (r < (ph == 0 ? 50 : 1)) m = M_RESEED;
                else if (r < (ph == 0 ? 100 : 3)) m = M_LOAD;
                else if (r < (ph == 0 ? 200 : 60)) m = M_HOLD;
                else m = M_RUN;
                rdy = ($urandom_range(0, 3) != 0);
                d   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                apply(m, rdy, d);
                check_model($sformatf("rand%0d_%0d", ph, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/lfsr_gen.md
LFSR_GEN -- requirements
Module: lfsr_gen

Interface
REQ-001 Parameter WIDTH, default 8: LFSR state width in bits; legal range 3..32.
REQ-002 Parameter TAPS, default 8'h1D: feedback mask, WIDTH bits wide; bit i set means state bit i feeds the XOR.
REQ-003 Parameter SEED, default 8'h01: reset and reseed value, WIDTH bits wide; a value of zero is illegal.
REQ-004 Parameter CNT_W, default 16: width of the step counter and of period_len.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous reset, active low.
REQ-007 din  input  WIDTH  load value used in mode 01.
REQ-008 mode  input  2  00 = reseed, 01 = load, 10 = run, 11 = hold.
REQ-009 rand_ready  input  1  consumer accepts the current data word.
REQ-010 data  output  WIDTH  current LFSR state (registered).
REQ-011 rand_valid  output  1  combinational, equal to (mode == 10).
REQ-012 lockup  output  1  sticky flag: an all-zero state was recovered.
REQ-013 step_cnt  output  CNT_W  number of steps taken since the last load, reseed or period hit.
REQ-014 period_len  output  CNT_W  length of the last detected cycle.
REQ-015 period_pulse  output  1  one-cycle registered pulse on each period hit.

Function
REQ-016 Feedback fb SHALL be the XOR reduction of (data & TAPS); one step SHALL set data to {fb, data[WIDTH-1:1]}.
REQ-017 An internal register start SHALL hold the cycle-start reference value.
REQ-018 Mode 00 SHALL set data and start to SEED, clear step_cnt and clear lockup; period_len is unchanged.
REQ-019 Mode 01 SHALL set data and start to din, clear step_cnt and clear lockup; din = 0 SHALL be accepted without setting any flag.
REQ-020 Mode 10 with rand_ready = 1 SHALL perform one step per cycle (handshake: rand_valid & rand_ready).
REQ-021 Mode 10 with rand_ready = 0 SHALL leave every register unchanged (backpressure).
REQ-022 Mode 11 SHALL leave every register unchanged, regardless of rand_ready.
REQ-023 On a step taken from data = 0, the block SHALL perform a recovery instead of a normal step:
  - data and start set to SEED
  - lockup set to 1
  - step_cnt cleared
  - no period_pulse produced.
REQ-024 On a normal step, when the next data value equals start (a period hit):
  - period_len set to step_cnt + 1 (truncated to CNT_W bits)
  - step_cnt cleared
  - period_pulse set to 1 in the following cycle.
REQ-025 On a normal step that is not a period hit, step_cnt SHALL increment by 1, saturating at all-ones; period_len is unchanged.
REQ-026 period_pulse SHALL be 0 in every cycle not immediately following a period hit.
REQ-027 Mode is sampled every cycle with no latency; a mode change takes effect at the next rising edge.
REQ-028 A load or reseed in the cycle after a period hit SHALL NOT suppress that period_pulse.

Reset
REQ-029 While rst_n = 0, the block SHALL immediately hold:
  - data = SEED and start = SEED
  - lockup = 0, step_cnt = 0, period_len = 0, period_pulse = 0.
REQ-030 Reset SHALL override any mode, including mid-run.
REQ-031 The first step SHALL occur on the first rising edge after rst_n deasserts, given mode = 10 and rand_ready = 1.

Verification (WIDTH = 8, TAPS = 8'h1D, SEED = 8'h01, CNT_W = 16)
REQ-032 Reset, then mode = 10 with rand_ready = 1 for 2 cycles -> data 0x01 -> 0x80 -> 0x40; step_cnt = 2.
REQ-033 Mode = 10 with rand_ready toggling 1,0,1 starting from data = 0x01 -> data 0x80, 0x80, 0x40; step_cnt changes only on ready cycles.
REQ-034 Load din = 0x00, then run 1 cycle -> data = 0x01, lockup = 1, step_cnt = 0; a following reseed clears lockup.
REQ-035 Load 0x01, run until period_pulse -> period_len equals the cycle length from the bench model (255 if the taps are maximal); data = 0x01 at the hit; step_cnt = 0.
REQ-036 Assert rst_n = 0 asynchronously mid-run with data = 0x40 -> data = 0x01 and all counters and flags = 0 before the next clock edge.
REQ-037 Mode = 11 for 10 cycles with rand_ready = 1 -> data, step_cnt and period_len unchanged; period_pulse = 0.
